// File: rtl/ram_xy_pkg.sv
// ram_xy_pkg
//   Shared definitions for the XY coordinate RAM sequencer.
//   Holds the default geometry, the {x,y} word packing offsets and the
//   FSM state encoding.
package ram_xy_pkg;

  localparam int BITS_EJE_DEF         = 6;
  localparam int BITS_COORDENADA_DEF  = 2 * BITS_EJE_DEF;
  localparam int DIRECCIONAMIENTO_DEF = 4;
  localparam int PROFUNDIDAD          = 2 ** DIRECCIONAMIENTO_DEF;

  // Word = {x, y}, x in the MSBs
  localparam int X_MSB = BITS_COORDENADA_DEF - 1;
  localparam int X_LSB = BITS_EJE_DEF;
  localparam int Y_MSB = BITS_EJE_DEF - 1;

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    ESCRIBIR = 3'd1,
    LEER     = 3'd2,
    CAPTURAR = 3'd3,
    BORRAR   = 3'd4
  } estado_t;

endpackage

// File: rtl/secuenciador_ram_xy.sv
// secuenciador_ram_xy
//   Arbitrates the single-port XY coordinate RAM between the record path
//   (grabar) and the playback path (leer), and runs the full-RAM clear sweep.
//   Owns the write/read pointers and the fill count.
//
// Ports
//   clock, reset_n                  clock, async active-low reset
//   borrar, reiniciar_lectura       clear request / rewind playback pointer
//   grabar_req, x_sensor, y_sensor  record request and sample; grabar_ack accepts
//   leer_req                        playback request; x_salida/y_salida + dato_valido
//   rechazo                         pulse: record while full or play at end of path
//   ram_*                           registered RAM interface, sync 1-cycle read
//   cuenta, lleno, vacio            fill status
//   fin_trayectoria, ocupado        nothing left to play / FSM not idle
//
// State    | meaning
// ---------+------------------------------------------------------------
// REPOSO   | idle, arbitrates borrar > reiniciar > grabar > leer
// ESCRIBIR | RAM write cycle, grabar_ack high, pointer and count advance
// LEER     | RAM read address presented, waiting for sync read data
// CAPTURAR | read data registered to x_salida/y_salida, dato_valido next
// BORRAR   | zero-write sweep over every address, then pointers cleared
module secuenciador_ram_xy
  import ram_xy_pkg::*;
#(
  parameter int BITS_EJE         = BITS_EJE_DEF,
  parameter int BITS_COORDENADA  = BITS_COORDENADA_DEF,
  parameter int DIRECCIONAMIENTO = DIRECCIONAMIENTO_DEF
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        borrar,
  input  logic                        reiniciar_lectura,
  input  logic                        grabar_req,
  input  logic [BITS_EJE-1:0]         x_sensor,
  input  logic [BITS_EJE-1:0]         y_sensor,
  output logic                        grabar_ack,
  input  logic                        leer_req,
  output logic [BITS_EJE-1:0]         x_salida,
  output logic [BITS_EJE-1:0]         y_salida,
  output logic                        dato_valido,
  output logic                        rechazo,
  output logic [DIRECCIONAMIENTO-1:0] ram_direccion,
  output logic [BITS_COORDENADA-1:0]  ram_dato_escribir,
  output logic                        ram_escribir,
  input  logic [BITS_COORDENADA-1:0]  ram_dato_leer,
  output logic [DIRECCIONAMIENTO:0]   cuenta,
  output logic                        lleno,
  output logic                        vacio,
  output logic                        fin_trayectoria,
  output logic                        ocupado
);

  localparam logic [DIRECCIONAMIENTO:0]   CUENTA_LLENO = (DIRECCIONAMIENTO + 1)'(PROFUNDIDAD);
  localparam logic [DIRECCIONAMIENTO-1:0] ULTIMA_DIR   = '1;

  estado_t                     estado;
  logic [DIRECCIONAMIENTO-1:0] ptr_esc;
  // One bit wider than an address so a fully played 16-word path keeps
  // ptr_lec == cuenta instead of wrapping back to 0.
  logic [DIRECCIONAMIENTO:0]   ptr_lec;
  logic [DIRECCIONAMIENTO-1:0] barrido;

  assign grabar_ack      = (estado == ESCRIBIR);
  assign ocupado         = (estado != REPOSO);
  assign lleno           = (cuenta == CUENTA_LLENO);
  assign vacio           = (cuenta == '0);
  assign fin_trayectoria = (ptr_lec == cuenta);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado            <= REPOSO;
      ptr_esc           <= '0;
      ptr_lec           <= '0;
      cuenta            <= '0;
      barrido           <= '0;
      x_salida          <= '0;
      y_salida          <= '0;
      dato_valido       <= 1'b0;
      rechazo           <= 1'b0;
      ram_direccion     <= '0;
      ram_dato_escribir <= '0;
      ram_escribir      <= 1'b0;
    end else begin
      dato_valido <= 1'b0;
      rechazo     <= 1'b0;
      unique case (estado)
        REPOSO: begin
          if (borrar) begin
            estado  <= BORRAR;
            barrido <= '0;
          end else if (reiniciar_lectura) begin
            ptr_lec <= '0;
          end else if (grabar_req) begin
            if (lleno) begin
              rechazo <= 1'b1;
            end else begin
              estado            <= ESCRIBIR;
              ram_direccion     <= ptr_esc;
              ram_dato_escribir <= {x_sensor, y_sensor};
              ram_escribir      <= 1'b1;
            end
          end else if (leer_req && !dato_valido) begin
            // the cycle dato_valido is high the requester is still holding leer_req
            if (fin_trayectoria) begin
              rechazo <= 1'b1;
            end else begin
              estado        <= LEER;
              ram_direccion <= ptr_lec[DIRECCIONAMIENTO-1:0];
              ram_escribir  <= 1'b0;
            end
          end
        end
        ESCRIBIR: begin
          ptr_esc      <= ptr_esc + 1'b1;
          cuenta       <= cuenta + 1'b1;
          ram_escribir <= 1'b0;
          estado       <= REPOSO;
        end
        LEER: begin
          estado <= CAPTURAR;
        end
        CAPTURAR: begin
          x_salida    <= ram_dato_leer[X_MSB:X_LSB];
          y_salida    <= ram_dato_leer[Y_MSB:0];
          ptr_lec     <= ptr_lec + 1'b1;
          dato_valido <= 1'b1;
          estado      <= REPOSO;
        end
        BORRAR: begin
          // First BORRAR cycle only loads address 0; we leave once the
          // write to the last address has been presented for a full cycle.
          if (ram_escribir && (ram_direccion == ULTIMA_DIR)) begin
            ram_escribir <= 1'b0;
            ptr_esc      <= '0;
            ptr_lec      <= '0;
            cuenta       <= '0;
            estado       <= REPOSO;
          end else begin
            ram_direccion     <= barrido;
            ram_dato_escribir <= '0;
            ram_escribir      <= 1'b1;
            barrido           <= barrido + 1'b1;
          end
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_ram_xy.sv
// tb_secuenciador_ram_xy
//   Directed bench for secuenciador_ram_xy with a 16x12 synchronous-read RAM model.
module tb_secuenciador_ram_xy;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        borrar = 1'b0;
  logic        reiniciar_lectura = 1'b0;
  logic        grabar_req = 1'b0;
  logic [5:0]  x_sensor = '0;
  logic [5:0]  y_sensor = '0;
  logic        grabar_ack;
  logic        leer_req = 1'b0;
  logic [5:0]  x_salida, y_salida;
  logic        dato_valido, rechazo;
  logic [3:0]  ram_direccion;
  logic [11:0] ram_dato_escribir;
  logic        ram_escribir;
  logic [11:0] ram_dato_leer = '0;
  logic [4:0]  cuenta;
  logic        lleno, vacio, fin_trayectoria, ocupado;

  logic [11:0] mem [16];

  int n_chk = 0;
  int n_err = 0;

  // sweep monitor
  logic vigilar = 1'b0;
  int   zw_cnt = 0;
  int   zw_bad = 0;

  secuenciador_ram_xy dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .borrar            (borrar),
    .reiniciar_lectura (reiniciar_lectura),
    .grabar_req        (grabar_req),
    .x_sensor          (x_sensor),
    .y_sensor          (y_sensor),
    .grabar_ack        (grabar_ack),
    .leer_req          (leer_req),
    .x_salida          (x_salida),
    .y_salida          (y_salida),
    .dato_valido       (dato_valido),
    .rechazo           (rechazo),
    .ram_direccion     (ram_direccion),
    .ram_dato_escribir (ram_dato_escribir),
    .ram_escribir      (ram_escribir),
    .ram_dato_leer     (ram_dato_leer),
    .cuenta            (cuenta),
    .lleno             (lleno),
    .vacio             (vacio),
    .fin_trayectoria   (fin_trayectoria),
    .ocupado           (ocupado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_escribir) mem[ram_direccion] <= ram_dato_escribir;
    ram_dato_leer <= mem[ram_direccion];
    if (vigilar && ram_escribir) begin
      if (ram_dato_escribir != 12'h000 || ram_direccion != 4'(zw_cnt)) zw_bad++;
      zw_cnt++;
    end
  end

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic aplicar_reset();
    reset_n = 1'b0;
    borrar = 1'b0; reiniciar_lectura = 1'b0;
    grabar_req = 1'b0; leer_req = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic grabar(input logic [5:0] x, input logic [5:0] y);
    int n;
    x_sensor = x; y_sensor = y; grabar_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!grabar_ack && n < 10);
    comprobar("grabar_ack_lat", n, 1);
    grabar_req = 1'b0;
    tick();
  endtask

  task automatic leer(input logic [5:0] xe, input logic [5:0] ye);
    int n;
    leer_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!dato_valido && n < 8);
    comprobar("leer_lat", n, 3);
    comprobar("leer_x", x_salida, xe);
    comprobar("leer_y", y_salida, ye);
    leer_req = 1'b0;
    tick();
  endtask

  initial begin
    int n, t_ack, t_dv, nz;
    logic [11:0] w;

    for (int i = 0; i < 16; i++) mem[i] = 12'hA00 + 12'(i);

    // reset values
    reset_n = 1'b0;
    tick(); tick();
    comprobar("rst_cuenta", cuenta, 0);
    comprobar("rst_vacio", vacio, 1);
    comprobar("rst_fin", fin_trayectoria, 1);
    comprobar("rst_lleno", lleno, 0);
    comprobar("rst_ocupado", ocupado, 0);
    comprobar("rst_ram_esc", ram_escribir, 0);
    comprobar("rst_ack", grabar_ack, 0);
    comprobar("rst_dv", dato_valido, 0);
    reset_n = 1'b1;
    tick();

    // first record x=5 y=9
    x_sensor = 6'd5; y_sensor = 6'd9; grabar_req = 1'b1;
    tick();
    comprobar("g1_ack", grabar_ack, 1);
    comprobar("g1_we", ram_escribir, 1);
    comprobar("g1_addr", ram_direccion, 0);
    comprobar("g1_data", ram_dato_escribir, 12'h149);
    grabar_req = 1'b0;
    tick();
    comprobar("g1_ack_off", grabar_ack, 0);
    comprobar("g1_we_off", ram_escribir, 0);
    comprobar("g1_cuenta", cuenta, 1);
    comprobar("g1_vacio", vacio, 0);
    comprobar("g1_mem0", mem[0], 12'h149);

    // fill to 16, then a rejected record
    for (int i = 1; i < 16; i++) grabar(6'(i), 6'(i + 20));
    comprobar("full_cuenta", cuenta, 16);
    comprobar("full_lleno", lleno, 1);
    w = {6'd15, 6'd35};
    comprobar("full_mem15", mem[15], w);
    x_sensor = 6'd63; y_sensor = 6'd63; grabar_req = 1'b1;
    tick();
    comprobar("full_rechazo", rechazo, 1);
    comprobar("full_no_we", ram_escribir, 0);
    comprobar("full_no_ack", grabar_ack, 0);
    grabar_req = 1'b0;
    tick();
    comprobar("full_rechazo_off", rechazo, 0);
    comprobar("full_cuenta2", cuenta, 16);
    comprobar("full_mem15b", mem[15], w);

    // three records, three reads, one rejected read
    aplicar_reset();
    grabar(6'd1, 6'd2);
    grabar(6'd10, 6'd20);
    grabar(6'd33, 6'd44);
    comprobar("r3_fin_before", fin_trayectoria, 0);
    leer(6'd1, 6'd2);
    leer(6'd10, 6'd20);
    leer(6'd33, 6'd44);
    comprobar("r3_fin", fin_trayectoria, 1);
    leer_req = 1'b1;
    tick();
    comprobar("r4_rechazo", rechazo, 1);
    comprobar("r4_ocupado", ocupado, 0);
    comprobar("r4_dv", dato_valido, 0);
    leer_req = 1'b0;
    tick();
    // rewind and play the first sample again
    reiniciar_lectura = 1'b1;
    tick();
    reiniciar_lectura = 1'b0;
    comprobar("rew_fin", fin_trayectoria, 0);
    leer(6'd1, 6'd2);

    // simultaneous record + read
    aplicar_reset();
    grabar(6'd7, 6'd8);
    grabar(6'd11, 6'd12);
    x_sensor = 6'd21; y_sensor = 6'd22;
    grabar_req = 1'b1; leer_req = 1'b1;
    t_ack = 0; t_dv = 0; n = 0;
    while (t_dv == 0 && n < 15) begin
      tick(); n++;
      if (grabar_ack && t_ack == 0) begin t_ack = n; grabar_req = 1'b0; end
      if (dato_valido) begin
        t_dv = n;
        comprobar("sim_x", x_salida, 6'd7);
        comprobar("sim_y", y_salida, 6'd8);
        leer_req = 1'b0;
      end
    end
    grabar_req = 1'b0; leer_req = 1'b0;
    tick();
    comprobar("sim_t_ack", t_ack, 1);
    comprobar("sim_t_dv", t_dv, 5);
    comprobar("sim_cuenta", cuenta, 3);
    w = {6'd21, 6'd22};
    comprobar("sim_mem2", mem[2], w);

    // clear sweep with cuenta=7
    aplicar_reset();
    for (int i = 0; i < 7; i++) grabar(6'(i + 1), 6'(i + 40));
    comprobar("bor_cuenta7", cuenta, 7);
    zw_cnt = 0; zw_bad = 0; vigilar = 1'b1;
    borrar = 1'b1;
    tick();
    borrar = 1'b0;
    n = 0;
    while (ocupado && n < 40) begin n++; tick(); end
    vigilar = 1'b0;
    comprobar("bor_ocupado_ciclos", n, 17);
    comprobar("bor_escrituras", zw_cnt, 16);
    comprobar("bor_escr_malas", zw_bad, 0);
    comprobar("bor_cuenta", cuenta, 0);
    comprobar("bor_vacio", vacio, 1);
    comprobar("bor_fin", fin_trayectoria, 1);
    nz = 0;
    for (int i = 0; i < 16; i++) if (mem[i] != 12'h000) nz++;
    comprobar("bor_mem_nz", nz, 0);

    // reset during sweep at barrido=8
    aplicar_reset();
    for (int i = 0; i < 16; i++) mem[i] = 12'h100 + 12'(i);
    borrar = 1'b1;
    tick();
    borrar = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    comprobar("rb_ocupado_pre", ocupado, 1);
    reset_n = 1'b0;
    #1;
    comprobar("rb_ocupado", ocupado, 0);
    comprobar("rb_we", ram_escribir, 0);
    comprobar("rb_addr", ram_direccion, 0);
    comprobar("rb_vacio", vacio, 1);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    nz = 0;
    for (int i = 8; i < 16; i++) if (mem[i] != 12'h100 + 12'(i)) nz++;
    comprobar("rb_mem_hi_kept", nz, 0);
    comprobar("rb_mem0_cleared", mem[0], 12'h000);
    comprobar("rb_mem6_cleared", mem[6], 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
